// File: rtl/switch_event_capture.sv
// rtl/switch_event_capture.sv - debounced switch capture with show-ahead event FIFO
//
// Ports:
//   clk       system clock (single domain)
//   rst       synchronous active-high reset
//   sw_raw    asynchronous switch pins, WIDTH bits
//   state     current debounced switch value
//   rd_en     pop request; ignored while the FIFO is empty
//   rd_valid  FIFO holds at least one event
//   rd_data   head event: [31:16] changed-bit mask, [15:0] new debounced value
//   count     FIFO fill level
//   overflow  sticky: an event was dropped because the FIFO was full
//   clr_ovf   clears overflow at the next edge (a same-cycle drop wins)

module switch_event_capture #(
  parameter int WIDTH    = 16,
  parameter int DEBOUNCE = 1_000_000,
  parameter int FIFO_AW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   sw_raw,
  output logic [WIDTH-1:0]   state,
  input  logic               rd_en,
  output logic               rd_valid,
  output logic [31:0]        rd_data,
  output logic [FIFO_AW:0]   count,
  output logic               overflow,
  input  logic               clr_ovf
);

  localparam int CNT_W = $clog2(DEBOUNCE);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE - 1);
  localparam logic [FIFO_AW:0]  FULL_LVL = (FIFO_AW + 1)'(DEPTH);

  logic [WIDTH-1:0]   sync1;
  logic [WIDTH-1:0]   sync2;
  logic [WIDTH-1:0]   cand;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic [15:0]        ev_mask;
  logic [15:0]        ev_value;

  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               pop;
  logic               full;
  logic               wr_ok;
  logic               drop;

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Whole-vector debounce: any change of sync2 restarts the count, so a
  // glitch on one bit delays acceptance of every bit. The counter saturates
  // at DEBOUNCE-1 and stays there while the input is quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= '0;
      cnt  <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // A stable candidate that differs from the accepted value becomes an event.
  assign accept = (sync2 == cand) && (cnt == CNT_MAX) && (cand != state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else if (accept) begin
      state <= cand;
    end
  end

  // Event halves are zero-extended to 16 bits each.
  always_comb begin
    ev_mask                 = '0;
    ev_value                = '0;
    ev_mask[WIDTH-1:0]      = cand ^ state;
    ev_value[WIDTH-1:0]     = cand;
  end

  // FIFO control. When full, a same-cycle pop frees the head slot, which is
  // exactly where wr_ptr points, so the new event lands as the tail.
  assign rd_valid = (count != '0);
  assign full     = (count == FULL_LVL);
  assign pop      = rd_en && rd_valid;
  assign wr_ok    = accept && (!full || pop);
  assign drop     = accept && full && !pop;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= {ev_mask, ev_value};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      if (wr_ok && !pop) begin
        count <= count + (FIFO_AW + 1)'(1);
      end else if (pop && !wr_ok) begin
        count <= count - (FIFO_AW + 1)'(1);
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as clr_ovf keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
